// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the external memory port arbiter.
// State codes double as owner codes, so owner is a direct decode of the state register.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_F = 2'b01,
    ST_GNT_M = 2'b10
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_F    = 2'b01;
  localparam logic [1:0] OWN_M    = 2'b10;

  typedef struct packed {
    logic read;
    logic write;
    logic hb;
    logic lb;
  } ext_ctl_t;

  function automatic logic [1:0] owner_of(input state_e s);
    case (s)
      ST_GNT_F: owner_of = OWN_F;
      ST_GNT_M: owner_of = OWN_M;
      default:  owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-way grant selection from IDLE; purely combinational, zero latency.
// No backpressure of its own: it only chooses which requester the arbiter grants next.
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic   f_req,
  input  logic   m_req,
  input  logic   last_m,
  output state_e pick
);

  always_comb begin
    pick = ST_IDLE;
    if (f_req && m_req) begin
      // On a tie, fair mode hands the port to whoever was not served last.
      pick = (FAIR && last_m) ? ST_GNT_F : ST_GNT_M;
    end else if (m_req) begin
      pick = ST_GNT_M;
    end else if (f_req) begin
      pick = ST_GNT_F;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the 16-bit external memory port between fetch and memory stage; grant 1 cycle after req.
// Grant is held while the owner keeps req; ext_busy stalls the owner via x_blocked.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit FAIR      = 1'b1,
  parameter int MAX_BEATS = 4,
  parameter int AW        = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_address,
  output logic          f_blocked,
  input  logic          m_req,
  input  logic [AW-1:0] m_address,
  input  logic          m_read,
  input  logic          m_write,
  input  logic [15:0]   m_value,
  input  logic          m_hb,
  input  logic          m_lb,
  output logic          m_blocked,
  output logic [AW-1:0] ext_address,
  output logic          ext_read,
  output logic          ext_write,
  output logic [15:0]   ext_value,
  output logic          ext_hb,
  output logic          ext_lb,
  input  logic          ext_busy,
  input  logic [15:0]   ext_valueRead,
  output logic [15:0]   rdata,
  output logic          f_rvalid,
  output logic          m_rvalid,
  output logic [1:0]    owner,
  output logic          err_overrun
);

  localparam int CW = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BEATS + 1);

  state_e          state_q, state_d, pick;
  logic            last_m_q, last_m_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;
  logic            f_rvalid_q, f_rvalid_d;
  logic            m_rvalid_q, m_rvalid_d;
  logic            accept;
  ext_ctl_t        ext_ctl;

  mem_port_arbiter_arb_pick #(.FAIR(FAIR)) u_pick (
    .f_req  (f_req),
    .m_req  (m_req),
    .last_m (last_m_q),
    .pick   (pick)
  );

  always_comb begin
    state_d  = state_q;
    last_m_d = last_m_q;
    case (state_q)
      ST_IDLE: state_d = pick;
      // Releasing owner hands straight over to a waiting requester, no IDLE bubble.
      ST_GNT_F: if (!f_req) begin
        last_m_d = 1'b0;
        state_d  = m_req ? ST_GNT_M : ST_IDLE;
      end
      ST_GNT_M: if (!m_req) begin
        last_m_d = 1'b1;
        state_d  = f_req ? ST_GNT_F : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ext_address = '0;
    ext_value   = '0;
    ext_ctl     = '0;
    case (state_q)
      ST_GNT_F: begin
        ext_address = f_address;
        ext_ctl     = '{read: 1'b1, write: 1'b0, hb: 1'b1, lb: 1'b1};
      end
      ST_GNT_M: begin
        ext_address = m_address;
        ext_value   = m_value;
        ext_ctl     = '{read: m_read, write: m_write, hb: m_hb, lb: m_lb};
      end
      default: ;
    endcase
  end

  assign ext_read  = ext_ctl.read;
  assign ext_write = ext_ctl.write;
  assign ext_hb    = ext_ctl.hb;
  assign ext_lb    = ext_ctl.lb;

  assign accept = (state_q != ST_IDLE) && (ext_ctl.read || ext_ctl.write) && !ext_busy;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_d != state_q) begin
      beat_cnt_d = '0;
    end else if (accept && beat_cnt_q != CNT_SAT) begin
      beat_cnt_d = beat_cnt_q + CW'(1);
    end
    err_d      = err_q || (accept && beat_cnt_q >= CNT_MAX);
    // Read data returns one cycle after acceptance, even if the owner let go on that edge.
    f_rvalid_d = accept && ext_ctl.read && (state_q == ST_GNT_F);
    m_rvalid_d = accept && ext_ctl.read && (state_q == ST_GNT_M);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_m_q   <= 1'b0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      f_rvalid_q <= 1'b0;
      m_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_m_q   <= last_m_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      f_rvalid_q <= f_rvalid_d;
      m_rvalid_q <= m_rvalid_d;
    end
  end

  assign owner       = owner_of(state_q);
  assign f_blocked   = f_req && ((state_q != ST_GNT_F) || ext_busy);
  assign m_blocked   = m_req && ((state_q != ST_GNT_M) || ext_busy);
  assign rdata       = ext_valueRead;
  assign f_rvalid    = f_rvalid_q;
  assign m_rvalid    = m_rvalid_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fair (A) and fixed-priority (B) instances on shared stimulus.
// Read returns are scoreboarded; grant, blocking and error outputs are checked inline.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        f_req, m_req, m_read, m_write, m_hb, m_lb, ext_busy;
  logic [31:0] f_address, m_address;
  logic [15:0] m_value;
  logic [15:0] ext_valueRead = 16'h0;

  logic        a_f_blocked, a_m_blocked, a_ext_read, a_ext_write, a_ext_hb, a_ext_lb;
  logic        a_f_rvalid, a_m_rvalid, a_err;
  logic [31:0] a_ext_address;
  logic [15:0] a_ext_value, a_rdata;
  logic [1:0]  a_owner;

  logic        b_f_blocked, b_m_blocked, b_ext_read, b_ext_write, b_ext_hb, b_ext_lb;
  logic        b_f_rvalid, b_m_rvalid, b_err;
  logic [31:0] b_ext_address;
  logic [15:0] b_ext_value, b_rdata;
  logic [1:0]  b_owner;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct {
    logic        is_m;
    logic [15:0] dat;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] ram_word(input logic [31:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  // RAM model: data for an accepted read appears the following cycle.
  always @(posedge clock)
    ext_valueRead <= (a_ext_read && !ext_busy) ? ram_word(a_ext_address) : 16'hDEAD;

  mem_port_arbiter #(.FAIR(1'b1), .MAX_BEATS(4), .AW(32)) dut_a (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_address(f_address), .f_blocked(a_f_blocked),
    .m_req(m_req), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_value(m_value), .m_hb(m_hb), .m_lb(m_lb), .m_blocked(a_m_blocked),
    .ext_address(a_ext_address), .ext_read(a_ext_read), .ext_write(a_ext_write),
    .ext_value(a_ext_value), .ext_hb(a_ext_hb), .ext_lb(a_ext_lb),
    .ext_busy(ext_busy), .ext_valueRead(ext_valueRead), .rdata(a_rdata),
    .f_rvalid(a_f_rvalid), .m_rvalid(a_m_rvalid), .owner(a_owner), .err_overrun(a_err)
  );

  mem_port_arbiter #(.FAIR(1'b0), .MAX_BEATS(4), .AW(32)) dut_b (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_address(f_address), .f_blocked(b_f_blocked),
    .m_req(m_req), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_value(m_value), .m_hb(m_hb), .m_lb(m_lb), .m_blocked(b_m_blocked),
    .ext_address(b_ext_address), .ext_read(b_ext_read), .ext_write(b_ext_write),
    .ext_value(b_ext_value), .ext_hb(b_ext_hb), .ext_lb(b_ext_lb),
    .ext_busy(ext_busy), .ext_valueRead(ext_valueRead), .rdata(b_rdata),
    .f_rvalid(b_f_rvalid), .m_rvalid(b_m_rvalid), .owner(b_owner), .err_overrun(b_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic push(input logic is_m, input logic [31:0] addr, input int at);
    sb.push_back('{is_m: is_m, dat: ram_word(addr), cyc: at});
  endtask

  task automatic clear_inputs();
    f_req = 1'b0; m_req = 1'b0; m_read = 1'b0; m_write = 1'b0;
    m_hb = 1'b0; m_lb = 1'b0; ext_busy = 1'b0;
    f_address = '0; m_address = '0; m_value = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step(); step();
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever A presents read data.
  initial forever begin
    exp_t e;
    @(negedge clock);
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests++; failed++;
      $display("FAIL rv_missing: got no rvalid, expected is_m=%0d data %0h at cycle %0d",
               sb[0].is_m, sb[0].dat, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (a_f_rvalid || a_m_rvalid) begin
      if (a_f_rvalid && a_m_rvalid) begin
        tests++; failed++;
        $display("FAIL rv_both: got f_rvalid=1 m_rvalid=1, expected at most one (cycle %0d)", cyc);
      end else if (sb.size() == 0) begin
        tests++; failed++;
        $display("FAIL rv_unexpected: got rvalid m=%0d data %0h, expected none (cycle %0d)",
                 a_m_rvalid, a_rdata, cyc);
      end else begin
        e = sb.pop_front();
        chk("rv_owner", {31'b0, a_m_rvalid}, {31'b0, e.is_m});
        chk("rv_data", {16'b0, a_rdata}, {16'b0, e.dat});
        chk("rv_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    step(); step();
    chk("rst_owner", a_owner, OWN_NONE);
    chk("rst_f_rvalid", a_f_rvalid, 0);
    chk("rst_m_rvalid", a_m_rvalid, 0);
    chk("rst_err", a_err, 0);
    chk("rst_ext_rd", a_ext_read, 0);
    chk("rst_ext_addr", a_ext_address, 0);
    reset = 1'b0;

    // Memory-stage 3-beat read
    step();
    m_req = 1'b1; m_read = 1'b1; m_address = 32'h100;
    #1;
    chk("t1_idle_owner", a_owner, OWN_NONE);
    chk("t1_m_blocked_wait", a_m_blocked, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      m_address = 32'h100 + k;
      push(1'b1, 32'h100 + k, cyc + 1);
      #1;
      chk("t1_owner_m", a_owner, OWN_M);
      chk("t1_m_blocked", a_m_blocked, 0);
      chk("t1_ext_addr", a_ext_address, 32'h100 + k);
      if (k == 2) m_req = 1'b0;
    end
    step();
    chk("t1_release", a_owner, OWN_NONE);
    m_read = 1'b0;
    step(); step();

    // Simultaneous requests after reset: memory first, then direct handover to fetch
    do_reset();
    f_req = 1'b1; f_address = 32'h40;
    m_req = 1'b1; m_read = 1'b1; m_address = 32'h200;
    push(1'b1, 32'h200, cyc + 2);
    push(1'b1, 32'h200, cyc + 3);
    push(1'b0, 32'h40, cyc + 4);
    step(); #1;
    chk("t2_owner_m", a_owner, OWN_M);
    chk("t2_b_owner_m", b_owner, OWN_M);
    chk("t2_f_blocked", a_f_blocked, 1);
    step();
    m_req = 1'b0; #1;
    chk("t2_owner_m2", a_owner, OWN_M);
    chk("t2_f_blocked2", a_f_blocked, 1);
    step(); #1;
    chk("t2_handover_f", a_owner, OWN_F);
    chk("t2_f_unblocked", a_f_blocked, 0);
    chk("t2_ext_rd_f", {a_ext_read, a_ext_write, a_ext_hb, a_ext_lb}, 4'b1011);
    chk("t2_ext_addr_f", a_ext_address, 32'h40);
    f_req = 1'b0;
    step();
    chk("t2_idle", a_owner, OWN_NONE);
    m_read = 1'b0;
    step(); step();

    // Repeated IDLE ties: A alternates M,F,M,F; B always picks M
    do_reset();
    m_read = 1'b1; f_address = 32'h300; m_address = 32'h400;
    for (int r = 0; r < 4; r++) begin
      logic exp_m;
      exp_m = (r % 2 == 0);
      f_req = 1'b1; m_req = 1'b1;
      step(); #1;
      chk("t3_a_owner", a_owner, exp_m ? OWN_M : OWN_F);
      chk("t3_b_owner", b_owner, OWN_M);
      chk("t3_a_f_blocked", a_f_blocked, {31'b0, exp_m});
      push(exp_m, exp_m ? 32'h400 : 32'h300, cyc + 1);
      f_req = 1'b0; m_req = 1'b0;
      step();
      chk("t3_idle", a_owner, OWN_NONE);
    end
    m_read = 1'b0;
    step();

    // ext_busy for 3 cycles during a fetch read
    f_address = 32'h40; f_req = 1'b1;
    step();
    ext_busy = 1'b1; #1;
    chk("t4_owner_f", a_owner, OWN_F);
    chk("t4_f_blocked0", a_f_blocked, 1);
    step(); #1;
    chk("t4_f_blocked1", a_f_blocked, 1);
    step(); #1;
    chk("t4_f_blocked2", a_f_blocked, 1);
    step();
    ext_busy = 1'b0; #1;
    chk("t4_f_unblocked", a_f_blocked, 0);
    push(1'b0, 32'h40, cyc + 1);
    f_req = 1'b0;
    step();
    chk("t4_idle", a_owner, OWN_NONE);
    step();

    // Reset during the second beat of a memory-stage read
    m_req = 1'b1; m_read = 1'b1; m_address = 32'h500;
    step();
    push(1'b1, 32'h500, cyc + 1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("t6_owner", a_owner, OWN_NONE);
    chk("t6_ext_rd", a_ext_read, 0);
    chk("t6_ext_wr", a_ext_write, 0);
    chk("t6_m_rvalid", a_m_rvalid, 0);
    m_req = 1'b0; m_read = 1'b0;
    step();
    reset = 1'b0;
    step(); step();

    // Five write beats with MAX_BEATS=4
    m_req = 1'b1; m_write = 1'b1; m_value = 16'h1234; m_hb = 1'b1; m_lb = 1'b0;
    m_address = 32'h600;
    step(); #1;
    chk("t7_ext_ctl", {a_ext_read, a_ext_write, a_ext_hb, a_ext_lb}, 4'b0110);
    chk("t7_ext_value", a_ext_value, 16'h1234);
    chk("t7_ext_addr", a_ext_address, 32'h600);
    step(); step(); step();
    chk("t7_err_after3", a_err, 0);
    step();
    chk("t7_err_after4", a_err, 0);
    m_req = 1'b0;
    step();
    chk("t7_err_after5", a_err, 1);
    chk("t7_owner_idle", a_owner, OWN_NONE);
    m_write = 1'b0;
    step(); step(); step();
    chk("t7_err_sticky", a_err, 1);

    step();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
